// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one single-ported, fixed-latency memory between
//            instruction fetch and the data path (load / store). One
//            requester is granted at a time. Each access runs through
//            ISSUE, WAIT (MEM_LAT cycles) and DONE, then returns to IDLE.
//            The read data is registered per requester and marked by a
//            one-cycle done pulse. Fetch starvation is bounded by STARVE_MAX.
// Ports    : clk, rst (async, active-low)
//            fetch  : if_req, if_addr -> if_rdata, if_done, stall_if
//            data   : dm_rd, dm_wr, dm_addr, dm_wdata -> dm_rdata, dm_done,
//                     stall_dm
//            memory : mem_en, mem_wr, mem_addr, mem_wdata <- mem_rdata
//            status : busy, err (sticky: read+write requested together)
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              dm_rd,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_dm,
    output logic              busy,
    output logic              err
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic             owner_dm;     // 1: data path owns the current access
    logic [CNT_W-1:0] lat_cnt;
    logic [STV_W-1:0] starve_cnt;

    logic dm_req;
    logic grant_dm;

    assign dm_req   = dm_rd | dm_wr;
    // Data wins unless fetch is waiting and has already been passed over
    // STARVE_MAX times in a row.
    assign grant_dm = dm_req && ((starve_cnt < STV_W'(STARVE_MAX)) || !if_req);

    assign stall_if = if_req & ~if_done;
    assign stall_dm = dm_req & ~dm_done;
    assign busy     = (state != IDLE);

    // mem_addr / mem_wdata / mem_wr double as the latched request: they are
    // loaded at grant, held through ISSUE and WAIT, and cleared for DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner_dm   <= 1'b0;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            mem_en     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            if_done    <= 1'b0;
            dm_done    <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_dm) begin
                        owner_dm  <= 1'b1;
                        mem_en    <= 1'b1;
                        // A combined read+write request is served as a write.
                        mem_wr    <= dm_wr;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        if (dm_rd && dm_wr) begin
                            err <= 1'b1;
                        end
                        if (!if_req) begin
                            starve_cnt <= '0;
                        end else if (starve_cnt != STV_W'(STARVE_MAX)) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                        state <= ISSUE;
                    end else if (if_req) begin
                        owner_dm   <= 1'b0;
                        mem_en     <= 1'b1;
                        mem_wr     <= 1'b0;
                        mem_addr   <= if_addr;
                        mem_wdata  <= '0;
                        starve_cnt <= '0;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en  <= 1'b0;
                    lat_cnt <= CNT_W'(MEM_LAT);
                    state   <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt == CNT_W'(1)) begin
                        // Final latency cycle: mem_rdata is valid now.
                        if (!mem_wr) begin
                            if (owner_dm) begin
                                dm_rdata <= mem_rdata;
                            end else begin
                                if_rdata <= mem_rdata;
                            end
                        end
                        if_done   <= ~owner_dm;
                        dm_done   <= owner_dm;
                        mem_wr    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        state     <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                DONE: begin
                    if_done <= 1'b0;
                    dm_done <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter. A behavioural memory with a
//            fixed read latency answers the DUT. It drives random data on
//            mem_rdata except in the one cycle where the read is valid.
//            Requesters push the expected responses and memory operations
//            into queues. A monitor pops and compares them whenever the DUT
//            strobes memory or pulses a done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int AW         = 16;
    localparam int DW         = 16;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } dop_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic          dm_rd = 1'b0;
    logic          dm_wr = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic [DW-1:0] dm_rdata;
    logic          dm_done;
    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          stall_if;
    logic          stall_dm;
    logic          busy;
    logic          err;

    mem_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MEM_LAT   (MEM_LAT),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_done  (if_done),
        .dm_rd    (dm_rd),
        .dm_wr    (dm_wr),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_done  (dm_done),
        .mem_en   (mem_en),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .stall_if (stall_if),
        .stall_dm (stall_dm),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Scoreboard state and reference memory
    logic [DW-1:0] exp_if_q[$];
    logic [DW-1:0] exp_dm_q[$];
    dop_t          exp_dop_q[$];
    logic [AW-1:0] exp_fop_q[$];
    bit            grant_log[$];      // 1 = data grant, 0 = fetch grant
    logic [DW-1:0] ref_mem[bit [AW-1:0]];
    logic [DW-1:0] env_mem[bit [AW-1:0]];
    logic [DW-1:0] last_dm = '0;
    int            n_cmp = 0;
    int            n_fail = 0;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C3C ^ {a[3:0], 12'h000};
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_val(a);
    endfunction

    function automatic logic [DW-1:0] env_rd(input logic [AW-1:0] a);
        if (env_mem.exists(a)) return env_mem[a];
        return init_val(a);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_fetch(input logic [AW-1:0] a);
        if_req  = 1'b1;
        if_addr = a;
        exp_if_q.push_back(ref_rd(a));
        exp_fop_q.push_back(a);
    endtask

    task automatic set_data(input logic rd, input logic wr,
                            input logic [AW-1:0] a, input logic [DW-1:0] wd);
        dop_t op;
        dm_rd    = rd;
        dm_wr    = wr;
        dm_addr  = a;
        dm_wdata = wd;
        op.wr    = wr;
        op.addr  = a;
        op.wdata = wd;
        if (wr) ref_mem[a] = wd;
        else    last_dm = ref_rd(a);
        exp_dm_q.push_back(last_dm);
        exp_dop_q.push_back(op);
    endtask

    task automatic wait_if_done();
        int n = 0;
        do begin @(negedge clk); n++; end while (!if_done && n < 100);
        check("if_done_seen", if_done, 1'b1);
    endtask

    task automatic wait_dm_done();
        int n = 0;
        do begin @(negedge clk); n++; end while (!dm_done && n < 100);
        check("dm_done_seen", dm_done, 1'b1);
    endtask

    task automatic fetch_agent(input int n);
        for (int i = 0; i < n; i++) begin
            int gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
            set_fetch({8'h00, 8'($urandom)});
            wait_if_done();
            @(posedge clk); #1;
            if_req = 1'b0;
        end
    endtask

    task automatic data_agent(input int n);
        for (int i = 0; i < n; i++) begin
            int gap = $urandom_range(0, 2);
            logic wr = 1'($urandom_range(0, 1));
            repeat (gap) begin @(posedge clk); #1; end
            set_data(~wr, wr, 16'h8000 | 16'($urandom_range(0, 15)), 16'($urandom));
            wait_dm_done();
            @(posedge clk); #1;
            dm_rd = 1'b0;
            dm_wr = 1'b0;
        end
    endtask

    // Memory model and monitor, sampled mid-cycle.
    int            cyc = 0;
    int            rd_due = -1;
    logic [DW-1:0] rd_val = '0;
    bit            have_rd = 0;
    bit            prev_if_req = 0;
    int            starve = 0;
    dop_t          mop;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            have_rd     = 0;
            prev_if_req = 0;
            starve      = 0;
        end else begin
            if (mem_en) begin
                if (exp_dop_q.size() > 0 && exp_dop_q[0].addr == mem_addr) begin
                    mop = exp_dop_q.pop_front();
                    check("dm_mem_wr", mem_wr, mop.wr);
                    if (mop.wr) check("dm_mem_wdata", mem_wdata, mop.wdata);
                    grant_log.push_back(1'b1);
                    if (prev_if_req) begin
                        starve++;
                        check("starve_bound", starve <= STARVE_MAX, 1'b1);
                    end else begin
                        starve = 0;
                    end
                end else if (exp_fop_q.size() > 0 && exp_fop_q[0] == mem_addr) begin
                    void'(exp_fop_q.pop_front());
                    check("if_mem_wr", mem_wr, 1'b0);
                    grant_log.push_back(1'b0);
                    starve = 0;
                end else begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL mem_access: got unexpected mem_addr %0h, required a queued request", mem_addr);
                end
                if (mem_wr) begin
                    env_mem[mem_addr] = mem_wdata;
                end else begin
                    have_rd = 1;
                    rd_due  = cyc + MEM_LAT;
                    rd_val  = env_rd(mem_addr);
                end
            end
            if (if_done) begin
                if (exp_if_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL if_done_unexpected: got pulse, required none");
                end else begin
                    check("if_rdata", if_rdata, exp_if_q.pop_front());
                end
            end
            if (dm_done) begin
                if (exp_dm_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL dm_done_unexpected: got pulse, required none");
                end else begin
                    check("dm_rdata", dm_rdata, exp_dm_q.pop_front());
                end
            end
            if (if_done || dm_done) check("done_exclusive", if_done & dm_done, 1'b0);
            check("stall_if", stall_if, if_req & ~if_done);
            check("stall_dm", stall_dm, (dm_rd | dm_wr) & ~dm_done);
            prev_if_req = if_req;
        end
        mem_rdata = (have_rd && cyc == rd_due) ? rd_val : 16'($urandom);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_log [6];
        exp_log = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        ref_mem[16'h0040] = 16'hA5A5;
        env_mem[16'h0040] = 16'hA5A5;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_dones", {if_done, dm_done}, 2'b00);
        check("rst_if_rdata", if_rdata, 16'h0000);
        check("rst_dm_rdata", dm_rdata, 16'h0000);
        check("rst_err", err, 1'b0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b1;

        // Fetch alone
        @(posedge clk); #1;
        set_fetch(16'h0040);
        tick(1);
        check("f_stall_c0", stall_if, 1'b1);
        tick(1);
        check("f_en_c1", mem_en, 1'b1);
        check("f_wr_c1", mem_wr, 1'b0);
        check("f_addr_c1", mem_addr, 16'h0040);
        tick(1);
        check("f_en_c2", mem_en, 1'b0);
        check("f_addr_c2", mem_addr, 16'h0040);
        tick(1);
        check("f_stall_c3", stall_if, 1'b1);
        check("f_done_c3", if_done, 1'b0);
        tick(1);
        check("f_done_c4", if_done, 1'b1);
        check("f_rdata_c4", if_rdata, 16'hA5A5);
        check("f_addr_c4", mem_addr, 16'h0000);
        @(posedge clk); #1;
        if_req = 1'b0;
        tick(1);
        check("f_idle_c5", {busy, if_done}, 2'b00);

        // Store
        @(posedge clk); #1;
        set_data(1'b0, 1'b1, 16'h1234, 16'hBEEF);
        tick(2);
        check("s_en_c1", mem_en, 1'b1);
        check("s_wr_c1", mem_wr, 1'b1);
        check("s_addr_c1", mem_addr, 16'h1234);
        check("s_wdata_c1", mem_wdata, 16'hBEEF);
        tick(3);
        check("s_done_c4", {dm_done, if_done}, 2'b10);
        check("s_rdata_c4", dm_rdata, 16'h0000);
        @(posedge clk); #1;
        dm_wr = 1'b0;

        // Contention: data served first, fetch after one IDLE cycle
        @(posedge clk); #1;
        set_fetch(16'h0042);
        set_data(1'b1, 1'b0, 16'h1234, 16'h0000);
        tick(2);
        check("c_addr_c1", mem_addr, 16'h1234);
        tick(3);
        check("c_done_c4", {dm_done, if_done}, 2'b10);
        check("c_rdata_c4", dm_rdata, 16'hBEEF);
        @(posedge clk); #1;
        dm_rd = 1'b0;
        tick(1);
        check("c_idle_c5", busy, 1'b0);
        tick(1);
        check("c_en_c6", mem_en, 1'b1);
        check("c_addr_c6", mem_addr, 16'h0042);
        tick(3);
        check("c_done_c9", {if_done, dm_done}, 2'b10);
        @(posedge clk); #1;
        if_req = 1'b0;

        // Starvation: fetch held, data back to back
        tick(2);
        grant_log.delete();
        @(posedge clk); #1;
        set_fetch(16'h0044);
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    set_data(1'b1, 1'b0, 16'(16'h2000 + i), 16'h0000);
                    wait_dm_done();
                    @(posedge clk); #1;
                end
                dm_rd = 1'b0;
            end
            begin
                wait_if_done();
                @(posedge clk); #1;
                if_req = 1'b0;
            end
        join
        check("starve_grants", grant_log.size() >= 6, 1'b1);
        for (int i = 0; i < 6; i++) begin
            if (i < grant_log.size()) check($sformatf("starve_order_%0d", i), grant_log[i], exp_log[i]);
        end

        // Reset in the middle of WAIT
        @(posedge clk); #1;
        set_fetch(16'h0046);
        tick(3);
        check("r_busy_wait", busy, 1'b1);
        check("r_addr_wait", mem_addr, 16'h0046);
        #1 rst = 1'b0;
        #1;
        check("r_outputs", {mem_en, mem_wr, busy, if_done, dm_done, err}, 6'b0);
        check("r_addr", mem_addr, 16'h0000);
        check("r_if_rdata", if_rdata, 16'h0000);
        check("r_dm_rdata", dm_rdata, 16'h0000);
        exp_if_q.delete();
        exp_fop_q.delete();
        last_dm = '0;
        tick(2);
        check("r_no_done", if_done, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_if_q.push_back(ref_rd(16'h0046));
        exp_fop_q.push_back(16'h0046);
        wait_if_done();
        @(posedge clk); #1;
        if_req = 1'b0;

        // Illegal read+write request
        @(posedge clk); #1;
        set_data(1'b1, 1'b1, 16'h1300, 16'h7777);
        tick(2);
        check("i_wr_c1", mem_wr, 1'b1);
        check("i_err_c1", err, 1'b1);
        tick(3);
        check("i_done_c4", dm_done, 1'b1);
        @(posedge clk); #1;
        dm_rd = 1'b0;
        dm_wr = 1'b0;
        @(posedge clk); #1;
        set_data(1'b1, 1'b0, 16'h1300, 16'h0000);
        wait_dm_done();
        @(posedge clk); #1;
        dm_rd = 1'b0;

        // Random traffic from both requesters
        fork
            fetch_agent(30);
            data_agent(30);
        join
        tick(6);
        check("drain_if", exp_if_q.size(), 0);
        check("drain_dm", exp_dm_q.size(), 0);
        check("drain_dop", exp_dop_q.size(), 0);
        check("drain_fop", exp_fop_q.size(), 0);
        check("err_sticky", err, 1'b1);
        #1 rst = 1'b0;
        #1;
        check("err_cleared", err, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
